// File: rtl/issue_tx.sv
`default_nettype none
// ============================================================================
//  Module   : issue_tx
//  Purpose  : Transmit side of the byte-serial issue link. Accepts one issue
//             request (32-bit key, 32-bit amount) and serialises it as eight
//             big-endian bytes on byte_out. Each byte is framed by one toggle
//             of newbyt, and a closing tick_out pulse fires the receiver's
//             commit. After reset, PRE_TOGS dummy toggles are sent once so
//             that the receiver can discard its first events.
//
//  Ports    : clk        in   1   system clock, rising edge
//             rst        in   1   synchronous, active-high reset
//             req_valid  in   1   request present
//             req_ready  out  1   high only while idle
//             req_key    in   32  key, captured on transfer
//             req_value  in   32  amount, captured on transfer
//             byte_out   out  8   current byte
//             newbyt     out  1   toggles once per byte
//             tick_out   out  1   commit strobe, TICK_CYC cycles
//             busy       out  1   high from transfer until done
//             done       out  1   one-cycle pulse, frame complete
//
//  Config   : ISSUE_TX_CKSUM_EN -- when defined, a ninth data slot carries
//             the XOR of the eight payload bytes before the commit tick.
//
//  Revision : 1.0  initial release
// ============================================================================
module issue_tx #(
  parameter int SETUP_CYC = 2,  // byte_out stable before the toggle (>=1)
  parameter int HOLD_CYC  = 2,  // byte_out held after the toggle (>=1)
  parameter int PRE_TOGS  = 2,  // dummy toggles sent once after reset
  parameter int TICK_CYC  = 4   // tick_out high time (>=1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_key,
  input  logic [31:0] req_value,
  output logic [7:0]  byte_out,
  output logic        newbyt,
  output logic        tick_out,
  output logic        busy,
  output logic        done
);

  // Slot and tick counters are kept at a fixed 16-bit width; the compare
  // constants below are pre-cast so every comparison is width-matched.
  localparam int          SLOT_CYC  = SETUP_CYC + HOLD_CYC;
  localparam logic [15:0] SLOT_LAST = 16'(SLOT_CYC - 1);
  localparam logic [15:0] TOG_AT    = 16'(SETUP_CYC);
  localparam bit          HAS_PRE   = (PRE_TOGS > 0);
  localparam logic [15:0] PRE_LAST  = HAS_PRE ? 16'(PRE_TOGS - 1) : 16'd0;
  localparam logic [15:0] TICK_LEN  = 16'(TICK_CYC);

`ifdef ISSUE_TX_CKSUM_EN
  localparam int             IDX_W    = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = 4'd8;   // slot 8 is the checksum
`else
  localparam int             IDX_W    = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_TICK = 2'd3
  } state_t;

  state_t           state;
  logic             pre_sent;   // preamble already sent since reset
  logic [63:0]      shreg;      // {key, value}, MSB byte goes out first
  logic [15:0]      slot_cyc;   // cycle position inside the current slot
  logic [15:0]      pre_idx;    // preamble slot number
  logic [15:0]      tick_cnt;   // cycles of tick_out already issued
  logic [IDX_W-1:0] byte_idx;   // data slot number
`ifdef ISSUE_TX_CKSUM_EN
  logic [7:0]       cksum;      // running XOR of payload bytes sent so far
`endif

  logic slot_first;
  logic slot_tog;
  logic slot_end;

  assign slot_first = (slot_cyc == 16'd0);
  assign slot_tog   = (slot_cyc == TOG_AT);
  assign slot_end   = (slot_cyc == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pre_sent  <= 1'b0;
      shreg     <= 64'd0;
      slot_cyc  <= 16'd0;
      pre_idx   <= 16'd0;
      tick_cnt  <= 16'd0;
      byte_idx  <= '0;
`ifdef ISSUE_TX_CKSUM_EN
      cksum     <= 8'h00;
`endif
      byte_out  <= 8'h00;
      newbyt    <= 1'b0;
      tick_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;

      case (state)
        // ------------------------------------------------------------------
        S_IDLE: begin
          if (req_valid && req_ready) begin
            shreg     <= {req_key, req_value};
            busy      <= 1'b1;
            req_ready <= 1'b0;
            slot_cyc  <= 16'd0;
            pre_idx   <= 16'd0;
            tick_cnt  <= 16'd0;
            byte_idx  <= '0;
`ifdef ISSUE_TX_CKSUM_EN
            cksum     <= 8'h00;
`endif
            // The preamble is a once-per-reset event, not once per frame.
            state     <= (!pre_sent && HAS_PRE) ? S_PRE : S_DATA;
          end
        end

        // ------------------------------------------------------------------
        // Dummy slots: same timing as data slots, byte_out forced to zero.
        S_PRE: begin
          if (slot_first) byte_out <= 8'h00;
          if (slot_tog)   newbyt   <= ~newbyt;
          if (slot_end) begin
            slot_cyc <= 16'd0;
            if (pre_idx == PRE_LAST) begin
              pre_idx  <= 16'd0;
              pre_sent <= 1'b1;
              state    <= S_DATA;
            end else begin
              pre_idx <= pre_idx + 16'd1;
            end
          end else begin
            slot_cyc <= slot_cyc + 16'd1;
          end
        end

        // ------------------------------------------------------------------
        // Each slot presents the top byte of the shift register at its first
        // cycle and shifts left so the next slot finds its byte on top.
        S_DATA: begin
          if (slot_first) begin
`ifdef ISSUE_TX_CKSUM_EN
            if (byte_idx == IDX_LAST) begin
              byte_out <= cksum;
            end else begin
              byte_out <= shreg[63:56];
              cksum    <= cksum ^ shreg[63:56];
              shreg    <= {shreg[55:0], 8'h00};
            end
`else
            byte_out <= shreg[63:56];
            shreg    <= {shreg[55:0], 8'h00};
`endif
          end
          if (slot_tog) newbyt <= ~newbyt;
          if (slot_end) begin
            slot_cyc <= 16'd0;
            if (byte_idx == IDX_LAST) begin
              byte_idx <= '0;
              state    <= S_TICK;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else begin
            slot_cyc <= slot_cyc + 16'd1;
          end
        end

        // ------------------------------------------------------------------
        // tick_out rises the cycle after the last slot; the cycle it falls is
        // also the done cycle, where the block is ready again.
        S_TICK: begin
          if (tick_cnt == TICK_LEN) begin
            tick_out  <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            tick_cnt  <= 16'd0;
            state     <= S_IDLE;
          end else begin
            tick_out <= 1'b1;
            tick_cnt <= tick_cnt + 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
